// File: rtl/serv_alu_seq_if.sv
// ----------------------------------------------------------------------------
// serv_alu_seq_if
// Bundles every non-clock/reset signal of serv_alu_seq:
//   upstream  : i_valid / o_ready handshake, parallel operands i_rs1/i_rs2/i_imm
//   ALU side  : o_en, o_cnt0, serial operand bits o_rs1/o_rs2/o_imm,
//               serial result i_rd and compare i_cmp
//   downstream: o_valid / i_ready handshake, o_result, o_cmp
// Signal names are from the block's point of view (i_ = into the block).
// slave  : used by serv_alu_seq itself
// master : used by whatever drives and consumes the block
// ----------------------------------------------------------------------------
interface serv_alu_seq_if #(
  parameter int W = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_rs1;
  logic [W-1:0] i_rs2;
  logic [W-1:0] i_imm;
  logic         o_en;
  logic         o_cnt0;
  logic         o_rs1;
  logic         o_rs2;
  logic         o_imm;
  logic         i_rd;
  logic         i_cmp;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_cmp;

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_imm, i_rd, i_cmp, i_ready,
    output o_ready, o_en, o_cnt0, o_rs1, o_rs2, o_imm, o_valid, o_result, o_cmp
  );

  modport master (
    output i_valid, i_rs1, i_rs2, i_imm, i_rd, i_cmp, i_ready,
    input  o_ready, o_en, o_cnt0, o_rs1, o_rs2, o_imm, o_valid, o_result, o_cmp
  );
endinterface

// File: rtl/serv_alu_seq.sv
// ----------------------------------------------------------------------------
// serv_alu_seq
// Parallel-to-serial front end and serial-to-parallel back end for a
// bit-serial ALU. An accepted operand triple is shifted out LSB-first over W
// cycles; the ALU's serial rd bits are collected into a parallel result and
// its compare output is captured on the last serial cycle.
//
// Ports
//   clk     : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : serv_alu_seq_if.slave (handshakes, operands, serial ALU link,
//             result)
//
// Timing: accept at edge E, W serial edges, o_valid high after edge E+W.
// One cycle in DONE (with i_ready high) plus one back in IDLE gives a minimum
// spacing of W+2 clocks between accepts.
// ----------------------------------------------------------------------------
module serv_alu_seq #(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          i_rst_n,
  serv_alu_seq_if.slave bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rs1_sr;
  logic [W-1:0]  rs2_sr;
  logic [W-1:0]  imm_sr;
  logic [W-1:0]  result_q;
  logic          cmp_q;

  logic accept;
  logic running;
  logic last;

  assign accept  = bus.i_valid && (state == IDLE);
  assign running = (state == RUN);
  assign last    = running && (cnt == CNT_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignment so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: default assigned first so no path through the case leaves
  // state_next unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.i_valid) state_next = RUN;
      RUN:     if (cnt == CNT_LAST) state_next = DONE;
      DONE:    if (bus.i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counter, operand shifters, result collector, compare capture
  // --------------------------------------------------------------------------
  // NOTE: all datapath registers are reset so an operation aborted by reset
  // leaves no stale operand or result bits behind.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      rs1_sr   <= '0;
      rs2_sr   <= '0;
      imm_sr   <= '0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      rs1_sr <= bus.i_rs1;
      rs2_sr <= bus.i_rs2;
      imm_sr <= bus.i_imm;
    end else if (running) begin
      // cnt wraps naturally from W-1 to 0 because W is a power of two.
      cnt      <= cnt + 1'b1;
      rs1_sr   <= {1'b0, rs1_sr[W-1:1]};
      rs2_sr   <= {1'b0, rs2_sr[W-1:1]};
      imm_sr   <= {1'b0, imm_sr[W-1:1]};
      // Bit sampled on serial cycle k ends up at position k after W shifts.
      result_q <= {bus.i_rd, result_q[W-1:1]};
      if (last) cmp_q <= bus.i_cmp;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registered state only, so neither handshake
  // output depends combinationally on the opposite handshake input.
  // --------------------------------------------------------------------------
  assign bus.o_ready  = (state == IDLE);
  assign bus.o_valid  = (state == DONE);
  assign bus.o_en     = running;
  assign bus.o_cnt0   = running && (cnt == '0);
  assign bus.o_rs1    = running && rs1_sr[0];
  assign bus.o_rs2    = running && rs2_sr[0];
  assign bus.o_imm    = running && imm_sr[0];
  assign bus.o_result = result_q;
  assign bus.o_cmp    = cmp_q;

endmodule

// File: tb/tb_serv_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_serv_alu_seq
// Drives serv_alu_seq with directed operand vectors. A serial ADD model
// produces i_rd from o_rs1/o_rs2; i_cmp follows a selectable pattern.
// Expected results are pushed into a scoreboard queue when an operation is
// issued; a monitor pops and compares at each result handshake.
// ----------------------------------------------------------------------------
module tb_serv_alu_seq;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cmp;
  } exp_t;

  logic clk;
  logic i_rst_n;

  serv_alu_seq_if #(.W(W)) ifc ();

  serv_alu_seq #(.W(W)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Serial ADD model and compare pattern generator
  // --------------------------------------------------------------------------
  logic carry;
  int   idx;
  int   cmp_mode;   // 0: never, 1: only on bit 31, 2: all bits except 31
  logic cin;
  int   cur_idx;

  assign cin     = ifc.o_cnt0 ? 1'b0 : carry;
  assign cur_idx = ifc.o_cnt0 ? 0 : idx;
  assign ifc.i_rd  = ifc.o_rs1 ^ ifc.o_rs2 ^ cin;
  assign ifc.i_cmp = (cmp_mode == 1) ? (ifc.o_en && cur_idx == W - 1) :
                     (cmp_mode == 2) ? (ifc.o_en && cur_idx != W - 1) : 1'b0;

  initial begin
    carry = 1'b0;
    idx   = 0;
  end

  always @(posedge clk) begin
    if (ifc.o_en) begin
      carry <= (ifc.o_rs1 & ifc.o_rs2) | (ifc.o_rs1 & cin) | (ifc.o_rs2 & cin);
      idx   <= cur_idx + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Serial-side monitor: counts o_cnt0 pulses, collects the o_imm stream
  // --------------------------------------------------------------------------
  int           cnt0_hits = 0;
  logic [W-1:0] imm_col   = '0;

  always @(negedge clk) begin
    if (ifc.o_cnt0) cnt0_hits++;
    if (ifc.o_en) imm_col = {ifc.o_imm, imm_col[W-1:1]};
  end

  // --------------------------------------------------------------------------
  // Scoreboard monitor
  // --------------------------------------------------------------------------
  exp_t sb_q[$];

  always @(negedge clk) begin
    if (i_rst_n && ifc.o_valid && ifc.i_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", ifc.o_result, e.result);
        check("sb_cmp", ifc.o_cmp, e.cmp);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic wait_ready();
    int n = 0;
    while (!ifc.o_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ifc.o_ready) check("timeout_ready", 0, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ifc.o_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ifc.o_valid) check("timeout_valid", 0, 1);
  endtask

  // Issue one operation; hold > 0 keeps i_ready low for that many DONE cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                        input int mode, input logic [W-1:0] exp_r, input logic exp_c,
                        input int hold);
    int   n;
    int   base;
    logic [W-1:0] r_snap;
    logic c_snap;
    cmp_mode    = mode;
    ifc.i_ready = (hold == 0);
    wait_ready();
    ifc.i_rs1   = a;
    ifc.i_rs2   = b;
    ifc.i_imm   = imm;
    ifc.i_valid = 1'b1;
    base        = cnt0_hits;
    @(posedge clk); #1;
    ifc.i_valid = 1'b0;
    sb_q.push_back('{result: exp_r, cmp: exp_c});
    check("ready_low_in_run", ifc.o_ready, 0);
    check("cnt0_first", ifc.o_cnt0, 1);
    wait_valid(n);
    check("latency_edges", n, W);
    check("cnt0_pulses", cnt0_hits - base, 1);
    check("imm_serial", imm_col, imm);
    check("en_low_in_done", ifc.o_en, 0);
    if (hold > 0) begin
      r_snap = ifc.o_result;
      c_snap = ifc.o_cmp;
      for (int i = 0; i < hold; i++) begin
        ifc.i_valid = i[0];
        ifc.i_rs1   = ~a;
        @(posedge clk); #1;
        check("bp_valid", ifc.o_valid, 1);
        check("bp_ready", ifc.o_ready, 0);
        check("bp_result", ifc.o_result, r_snap);
        check("bp_cmp", ifc.o_cmp, c_snap);
      end
      ifc.i_valid = 1'b0;
      ifc.i_ready = 1'b1;
    end
    // DONE -> IDLE edge; o_ready must not be high yet in DONE.
    check("ready_low_in_done", ifc.o_ready, 0);
    @(posedge clk); #1;
    check("ready_after_done", ifc.o_ready, 1);
    check("valid_after_done", ifc.o_valid, 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int            acc_cyc[4];
    logic [W-1:0]  va[4];
    logic [W-1:0]  vb[4];
    logic [W-1:0]  vr[4];
    int            cyc;

    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    ifc.i_rs1   = '0;
    ifc.i_rs2   = '0;
    ifc.i_imm   = '0;
    cmp_mode    = 0;
    i_rst_n     = 1'b0;

    #12;
    check("rst_ready", ifc.o_ready, 1);
    check("rst_valid", ifc.o_valid, 0);
    check("rst_en", ifc.o_en, 0);
    check("rst_cnt0", ifc.o_cnt0, 0);
    check("rst_result", ifc.o_result, 0);
    check("rst_cmp", ifc.o_cmp, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ADD, wrap, assorted patterns.
    run_op(32'd5,        32'd7,        32'hA5A5_0F0F, 0, 32'd12,        1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1,       32'h8000_0001, 0, 32'h0000_0000, 1'b0, 0);
    run_op(32'h1234_5678, 32'h1111_1111, 32'h0,       0, 32'h2345_6789, 1'b0, 0);
    run_op(32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b0, 0);

    // Compare capture on the last serial cycle only.
    run_op(32'd3,        32'd4,        32'h1,         1, 32'd7,         1'b1, 0);
    run_op(32'd3,        32'd4,        32'h2,         2, 32'd7,         1'b0, 0);

    // Backpressure in DONE with ignored i_valid pulses.
    run_op(32'hDEAD_BEEF, 32'h0101_0101, 32'h3C3C_3C3C, 1, 32'hDFAE_BFF0, 1'b1, 10);

    // Reset mid-RUN at cnt == 12.
    cmp_mode    = 0;
    wait_ready();
    ifc.i_rs1   = 32'hFFFF_0000;
    ifc.i_rs2   = 32'h0000_FFFF;
    ifc.i_valid = 1'b1;
    @(posedge clk); #1;
    ifc.i_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check("mid_run_en", ifc.o_en, 1);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_en", ifc.o_en, 0);
    check("rst_mid_ready", ifc.o_ready, 1);
    check("rst_mid_result", ifc.o_result, 0);
    check("rst_mid_valid", ifc.o_valid, 0);
    check("rst_mid_rs1", ifc.o_rs1, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    run_op(32'h8000_0000, 32'h8000_0000, 32'h7, 0, 32'h0, 1'b0, 0);

    // Back-to-back with i_valid and i_ready tied high.
    va = '{32'd1, 32'd100, 32'hFFFF_FFFE, 32'h0F0F_0F0F};
    vb = '{32'd2, 32'd200, 32'd3,         32'hF0F0_F0F0};
    vr = '{32'd3, 32'd300, 32'd1,         32'hFFFF_FFFF};
    cmp_mode    = 0;
    ifc.i_ready = 1'b1;
    wait_ready();
    cyc = 0;
    ifc.i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int guard = 0;
      ifc.i_rs1 = va[i];
      ifc.i_rs2 = vb[i];
      while (!ifc.o_ready && guard < 100) begin
        @(posedge clk); #1; cyc++; guard++;
      end
      if (!ifc.o_ready) check("timeout_b2b", 0, 1);
      @(posedge clk); #1; cyc++;
      acc_cyc[i] = cyc;
      sb_q.push_back('{result: vr[i], cmp: 1'b0});
    end
    ifc.i_valid = 1'b0;
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], W + 2);
    begin
      int n;
      wait_valid(n);
    end
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serv_alu_seq.md
SERV_ALU_SEQ -- requirements
Module: serv_alu_seq

Purpose: parallel-to-serial front end and serial-to-parallel back end for the bit-serial ALU. Serializes latched operands LSB-first into the ALU and collects its rd and compare outputs into a parallel result.

Interface
- REQ-001 SHALL have parameter W, default 32, operand/result width in bits (power of two, >= 4).
- REQ-002 SHALL have port clk, input, 1, rising-edge clock.
- REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have port i_valid, input, 1, upstream operand request.
- REQ-005 SHALL have port o_ready, output, 1, block can accept operands.
- REQ-006 SHALL have ports i_rs1, i_rs2, i_imm, inputs, W each, parallel operands.
- REQ-007 SHALL have port o_en, output, 1, serial-phase enable to the ALU.
- REQ-008 SHALL have port o_cnt0, output, 1, high on the first (bit 0) serial cycle.
- REQ-009 SHALL have ports o_rs1, o_rs2, o_imm, outputs, 1 each, current serial operand bits.
- REQ-010 SHALL have port i_rd, input, 1, serial result bit from the ALU.
- REQ-011 SHALL have port i_cmp, input, 1, ALU compare output.
- REQ-012 SHALL have port o_valid, output, 1, result available.
- REQ-013 SHALL have port i_ready, input, 1, downstream accepts the result.
- REQ-014 SHALL have port o_result, output, W, collected parallel result.
- REQ-015 SHALL have port o_cmp, output, 1, compare result captured on the last serial cycle.

Function
- REQ-016 SHALL implement the FSM states IDLE, RUN and DONE, with a log2(W)-bit counter cnt.
- REQ-017 SHALL drive o_ready = (state == IDLE); an accept is i_valid & o_ready at a rising edge.
- REQ-018 On accept, SHALL load i_rs1, i_rs2 and i_imm into three W-bit shift registers, clear cnt to 0, and enter RUN.
- REQ-019 In RUN, SHALL drive o_en = 1; o_rs1, o_rs2 and o_imm SHALL equal bit 0 of their shift registers.
- REQ-020 In RUN, each edge SHALL shift the operand registers right by one (MSB filled with 0) and increment cnt.
- REQ-021 SHALL drive o_cnt0 = 1 only in RUN with cnt == 0.
- REQ-022 Each RUN edge SHALL shift the result register as {i_rd, result[W-1:1]}, so that after W edges o_result[k] = i_rd sampled on serial cycle k.
- REQ-023 On the RUN edge with cnt == W-1, SHALL capture i_cmp into o_cmp, wrap cnt to 0, and enter DONE.
- REQ-024 In DONE, SHALL drive o_valid = 1 and hold o_result and o_cmp stable.
- REQ-025 When i_ready = 1 in DONE, SHALL enter IDLE; o_ready SHALL rise on the following cycle (no same-cycle re-accept).
- REQ-026 Latency SHALL be W+1 clocks: accept at edge E, o_valid high after edge E+W.
- REQ-027 Throughput SHALL be at most one operation per W+2 clocks with i_ready tied high.
- REQ-028 i_valid while in RUN or DONE SHALL be ignored, with no effect on any register.
- REQ-029 In IDLE and DONE, SHALL drive o_en, o_cnt0, o_rs1, o_rs2 and o_imm to 0.
- REQ-030 o_valid SHALL NOT depend combinationally on i_ready; o_ready SHALL NOT depend combinationally on i_valid.

Reset
- REQ-031 Asserting i_rst_n = 0 at any time, including mid-RUN, SHALL immediately force the following, with no pending operation resumed:
  - state IDLE and cnt 0;
  - o_ready 1;
  - o_valid, o_en and o_cnt0 0;
  - o_result 0 and o_cmp 0;
  - operand shift registers 0.
- REQ-032 Release of i_rst_n SHALL be sampled synchronously; the first accept is possible on the first rising edge after release.

Verification
- REQ-033 Bench SHALL cover W=32 with a serial ADD model on i_rd: rs1=5, rs2=7 -> o_valid after 33 clocks, o_result=12, o_cnt0 high exactly one cycle.
- REQ-034 Bench SHALL cover wrap: rs1=0xFFFFFFFF, rs2=1 with serial ADD -> o_result=0x00000000.
- REQ-035 Bench SHALL cover backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid, o_result and o_cmp stable; i_valid pulses ignored; o_ready low throughout.
- REQ-036 Bench SHALL cover compare capture: i_cmp=1 only on cnt==31 -> o_cmp=1; i_cmp=1 on all cycles except cnt==31 -> o_cmp=0.
- REQ-037 Bench SHALL cover reset mid-RUN: deassert i_rst_n at cnt==12 -> next sample shows o_en=0, o_ready=1, o_result=0; a new accept completes normally.
- REQ-038 Bench SHALL cover back-to-back transfers with i_valid and i_ready tied high -> accepts spaced exactly 34 clocks apart, all results correct.
